pbus_arbiter: RTL and testbench

//  Shares the 32-bit peripheral bus between NUM_REQ requesters (port 0 = CPU data-side

---
 rtl/pbus_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/pbus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_pbus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pbus_pkg.sv
// Shared widths, FSM state type and latched request payload for the peripheral bus arbiter.
package pbus_pkg;

    localparam int unsigned PBUS_AW  = 32;
    localparam int unsigned PBUS_DW  = 32;
    localparam int unsigned PBUS_BEW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } pbus_state_e;

    typedef struct packed {
        logic                we;
        logic [PBUS_BEW-1:0] be;
        logic [PBUS_AW-1:0]  addr;
        logic [PBUS_DW-1:0]  wdata;
    } pbus_req_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching ptr, ptr+1, ... mod N.
// Ports:
//   req       in  N   request vector
//   ptr       in  IW  highest-priority index for this pick
//   gnt_oh_c  out N   one-hot winner (zero when no request)
//   idx_c     out IW  winner index
//   any_c     out 1   at least one request present
module rr_arbiter
    import pbus_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    // Rotating priority search; ptr is always < N so one subtraction wraps it.
    always_comb begin
        gnt_oh_c = '0;
        idx_c    = '0;
        any_c    = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned j;
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_c && req[IW'(j)]) begin
                any_c            = 1'b1;
                idx_c            = IW'(j);
                gnt_oh_c[IW'(j)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pbus_arbiter.sv
// Shares the 32-bit peripheral bus between NUM_REQ requesters: round-robin pick,
// one outstanding transaction, valid/ready bus handshake, per-transaction timeout.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req/req_we               per-requester request level and write flag
//   req_be/req_addr/req_wdata  packed per-requester fields (requester i at slice i)
//   gnt, done                one-cycle pulses: request latched / transaction complete
//   resp_rdata, resp_err     response, non-zero only in the done cycle
//   busy                     transaction in progress
//   bus_valid/we/be/addr/wdata  bus request, fields held from the grant
//   bus_ready, bus_rdata     peripheral completion and read data
module pbus_arbiter
    import pbus_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [PBUS_BEW*NUM_REQ-1:0]  req_be,
    input  logic [PBUS_AW*NUM_REQ-1:0]   req_addr,
    input  logic [PBUS_DW*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [PBUS_DW-1:0]           resp_rdata,
    output logic                         resp_err,
    output logic                         busy,
    output logic                         bus_valid,
    output logic                         bus_we,
    output logic [PBUS_BEW-1:0]          bus_be,
    output logic [PBUS_AW-1:0]           bus_addr,
    output logic [PBUS_DW-1:0]           bus_wdata,
    input  logic                         bus_ready,
    input  logic [PBUS_DW-1:0]           bus_rdata
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

    pbus_state_e          state, state_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt;
    logic [IDX_W-1:0]     cur_idx, cur_idx_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    pbus_req_t            lat, lat_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt, done_nxt;
    logic [PBUS_DW-1:0]   rdata_nxt;
    logic                 err_nxt;
    logic                 valid_nxt;

    logic [NUM_REQ-1:0]   pick_oh_c;
    logic [IDX_W-1:0]     pick_idx_c;
    logic                 pick_any_c;
    pbus_req_t            sel_req_c;
    logic                 timeout_hit_c;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr (
        .req      (req),
        .ptr      (ptr),
        .gnt_oh_c (pick_oh_c),
        .idx_c    (pick_idx_c),
        .any_c    (pick_any_c)
    );

    // Fields of the winning requester, captured at the grant.
    always_comb begin
        sel_req_c       = '0;
        sel_req_c.we    = req_we[pick_idx_c];
        sel_req_c.be    = req_be[32'(pick_idx_c) * PBUS_BEW +: PBUS_BEW];
        sel_req_c.addr  = req_addr[32'(pick_idx_c) * PBUS_AW +: PBUS_AW];
        sel_req_c.wdata = req_wdata[32'(pick_idx_c) * PBUS_DW +: PBUS_DW];
    end

    // Expiry on the last allowed waiting cycle; counter starts at 0 in the first ISSUE cycle.
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
        assign timeout_hit_c = 1'b0;
    end else begin : g_timeout
        assign timeout_hit_c = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cur_idx_nxt = cur_idx;
        cnt_nxt     = cnt;
        lat_nxt     = lat;
        gnt_nxt     = '0;
        done_nxt    = '0;
        rdata_nxt   = '0;
        err_nxt     = 1'b0;
        valid_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any_c) begin
                    state_nxt   = ISSUE;
                    cur_idx_nxt = pick_idx_c;
                    lat_nxt     = sel_req_c;
                    gnt_nxt     = pick_oh_c;
                    cnt_nxt     = '0;
                    valid_nxt   = 1'b1;
                end
            end
            ISSUE: begin
                valid_nxt = 1'b1;
                // Ready takes priority over a timeout expiring in the same cycle.
                if (bus_ready) begin
                    state_nxt         = RESP;
                    valid_nxt         = 1'b0;
                    done_nxt[cur_idx] = 1'b1;
                    rdata_nxt         = lat.we ? '0 : bus_rdata;
                end else if (timeout_hit_c) begin
                    state_nxt         = RESP;
                    valid_nxt         = 1'b0;
                    done_nxt[cur_idx] = 1'b1;
                    err_nxt           = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
                ptr_nxt   = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cur_idx    <= '0;
            cnt        <= '0;
            lat        <= '0;
            gnt        <= '0;
            done       <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            bus_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            cur_idx    <= cur_idx_nxt;
            cnt        <= cnt_nxt;
            lat        <= lat_nxt;
            gnt        <= gnt_nxt;
            done       <= done_nxt;
            resp_rdata <= rdata_nxt;
            resp_err   <= err_nxt;
            busy       <= (state_nxt != IDLE);
            bus_valid  <= valid_nxt;
        end
    end

    assign bus_we    = lat.we;
    assign bus_be    = lat.be;
    assign bus_addr  = lat.addr;
    assign bus_wdata = lat.wdata;

endmodule

// File: tb/tb_pbus_arbiter.sv
// Randomized bench for pbus_arbiter with a transaction-timing reference model.
module tb_pbus_arbiter;
    import pbus_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [N-1:0]         req, req_we;
    logic [4*N-1:0]       req_be;
    logic [32*N-1:0]      req_addr, req_wdata;
    logic [N-1:0]         gnt, done;
    logic [31:0]          resp_rdata;
    logic                 resp_err, busy, bus_valid, bus_we;
    logic [3:0]           bus_be;
    logic [31:0]          bus_addr, bus_wdata;
    logic                 bus_ready;
    logic [31:0]          bus_rdata;

    pbus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_be(req_be),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int          cyc     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Requester agents
    logic        r_req   [N];
    logic        r_we    [N];
    logic [3:0]  r_be    [N];
    logic [31:0] r_addr  [N];
    logic [31:0] r_wdata [N];
    int          req_pct  = 0;
    int          keep_pct = 0;
    int          rdy_pct  = 100;
    int          rst_hold = 0;

    // Reference model: one transaction record plus arbitration pointer
    logic        m_active = 1'b0;
    int          m_g = 0, m_idx = 0, m_ptr = 0, m_next_dec = 0;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    int          gnt_log[$];
    int          n_to = 0;

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req[i]              = r_req[i];
            req_we[i]           = r_we[i];
            req_be[i*4 +: 4]    = r_be[i];
            req_addr[i*32 +: 32]  = r_addr[i];
            req_wdata[i*32 +: 32] = r_wdata[i];
        end
    endtask

    task automatic new_fields(input int i);
        r_we[i]    = 1'($urandom_range(1));
        r_be[i]    = 4'($urandom_range(15));
        r_addr[i]  = $urandom;
        r_wdata[i] = $urandom;
    endtask

    // Compare outputs against the model; port inputs still hold what the last edge sampled.
    task automatic check_cycle();
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_done;
        logic [31:0]  e_rdata;
        logic         e_err, e_valid, e_busy;
        e_gnt = '0; e_done = '0; e_rdata = '0; e_err = 1'b0; e_valid = 1'b0; e_busy = 1'b0;
        if (rst) begin
            m_active   = 1'b0;
            m_ptr      = 0;
            m_next_dec = cyc;
            check("rst_bus_addr", bus_addr, 0);
            check("rst_bus_wdata", bus_wdata, 0);
        end else begin
            if (m_active && cyc > m_g && (bus_ready || (cyc - m_g == TO))) begin
                e_done[m_idx] = 1'b1;
                e_err         = !bus_ready;
                e_rdata       = (bus_ready && !m_we) ? bus_rdata : 32'h0;
                if (e_err) n_to++;
                m_ptr      = (m_idx + 1) % N;
                m_active   = 1'b0;
                m_next_dec = cyc + 1;
            end else if (!m_active && cyc - 1 >= m_next_dec && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!m_active && req[j]) begin
                        m_active = 1'b1;
                        m_idx    = j;
                    end
                end
                e_gnt[m_idx] = 1'b1;
                m_g     = cyc;
                m_we    = req_we[m_idx];
                m_be    = req_be[m_idx*4 +: 4];
                m_addr  = req_addr[m_idx*32 +: 32];
                m_wdata = req_wdata[m_idx*32 +: 32];
                gnt_log.push_back(m_idx);
            end
            e_valid = m_active;
            e_busy  = m_active || (e_done != '0);
        end
        check("gnt", gnt, e_gnt);
        check("done", done, e_done);
        check("resp_rdata", resp_rdata, e_rdata);
        check("resp_err", resp_err, e_err);
        check("bus_valid", bus_valid, e_valid);
        check("busy", busy, e_busy);
        if (e_valid) begin
            check("bus_we", bus_we, m_we);
            check("bus_be", bus_be, m_be);
            check("bus_addr", bus_addr, m_addr);
            check("bus_wdata", bus_wdata, m_wdata);
        end
    endtask

    // Agent behaviour for the next cycle.
    task automatic drive_cycle();
        rst = (rst_hold > 0);
        if (rst_hold > 0) rst_hold--;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                // Kept high means a fresh request; fields change either way after the grant.
                new_fields(i);
                r_req[i] = ($urandom_range(99) < 32'(keep_pct));
            end else if (!r_req[i] && $urandom_range(99) < 32'(req_pct)) begin
                r_req[i] = 1'b1;
                new_fields(i);
            end
        end
        apply();
        bus_ready = ($urandom_range(99) < 32'(rdy_pct));
        bus_rdata = $urandom;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_cycle();
        drive_cycle();
    endtask

    task automatic reset_phase();
        req_pct = 0; keep_pct = 0;
        for (int i = 0; i < N; i++) r_req[i] = 1'b0;
        rst_hold = 2;
        repeat (3) step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0;
            new_fields(i);
        end
        rst = 1'b1;
        rst_hold = 2;
        apply();
        bus_ready = 1'b0;
        bus_rdata = '0;
        repeat (3) step();

        // Single write from requester 0, ready high
        gnt_log.delete();
        rdy_pct = 100;
        r_req[0] = 1'b1; r_we[0] = 1'b1; r_be[0] = 4'hF;
        r_addr[0] = 32'h1000_0004; r_wdata[0] = 32'hDEAD_BEEF;
        apply();
        repeat (6) step();
        check("write_gnt_count", 64'(gnt_log.size()), 1);
        if (gnt_log.size() > 0) check("write_gnt_idx", 64'(gnt_log[0]), 0);

        // Read from requester 1 with wait states
        reset_phase();
        rdy_pct = 0;
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_be[1] = 4'hF; r_addr[1] = 32'h1000_0008;
        apply();
        repeat (3) step();
        rdy_pct = 100;
        repeat (4) step();

        // Fairness: requesters 0 and 1 always requesting
        reset_phase();
        gnt_log.delete();
        keep_pct = 100; rdy_pct = 100;
        r_req[0] = 1'b1; r_req[1] = 1'b1;
        apply();
        repeat (20) step();
        check("fair_count", 64'(gnt_log.size() >= 6), 1);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++)
            check("fair_order", 64'(gnt_log[k]), 64'(k % 2));

        // Timeouts: ready never asserted
        reset_phase();
        n_to = 0;
        req_pct = 40; keep_pct = 20; rdy_pct = 0;
        repeat (60) step();
        check("timeouts_seen", 64'(n_to > 3), 1);

        // Reset while requester 1 is waiting on the bus; pointer must restart at 0
        reset_phase();
        rdy_pct = 100;
        r_req[0] = 1'b1; new_fields(0); apply();
        repeat (5) step();
        rdy_pct = 0;
        r_req[1] = 1'b1; new_fields(1); apply();
        repeat (3) step();
        rst_hold = 1;
        step();
        step();
        gnt_log.delete();
        rdy_pct = 100;
        r_req[0] = 1'b1; new_fields(0);
        r_req[1] = 1'b1; new_fields(1);
        apply();
        repeat (4) step();
        check("rst_ptr_count", 64'(gnt_log.size() > 0), 1);
        if (gnt_log.size() > 0) check("rst_ptr_gnt", 64'(gnt_log[0]), 0);

        // Random traffic with occasional resets
        gnt_log.delete();
        req_pct = 25; keep_pct = 30; rdy_pct = 35;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(299) == 0) rst_hold = 1;
            if (c == 2000) rdy_pct = 80;
            step();
        end
        check("random_progress", 64'(gnt_log.size() > 200), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
